// File: rtl/mic_pkg.sv
// Shared definitions for the microphone-array correlation path: default widths
// and the peak-finder state encoding.
package mic_pkg;

  localparam int XC_ADDR_W = 8;
  localparam int XC_DATA_W = 8;
  localparam int XC_CENTER = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } peak_state_t;

endpackage

// File: rtl/rd_align_pipe.sv
// RD_LAT-deep delay line that carries a valid flag and address alongside a RAM
// read so the returned data can be matched to the address that produced it.
module rd_align_pipe #(
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr
);

  logic              vld_q  [RD_LAT];
  logic              vld_d  [RD_LAT];
  logic [ADDR_W-1:0] addr_q [RD_LAT];
  logic [ADDR_W-1:0] addr_d [RD_LAT];

  genvar gi;
  generate
    for (gi = 0; gi < RD_LAT; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign vld_d[gi]  = in_valid;
        assign addr_d[gi] = in_addr;
      end else begin : g_tail
        assign vld_d[gi]  = vld_q[gi-1];
        assign addr_d[gi] = addr_q[gi-1];
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          vld_q[gi]  <= 1'b0;
          addr_q[gi] <= '0;
        end else begin
          vld_q[gi]  <= vld_d[gi];
          addr_q[gi] <= addr_d[gi];
        end
      end
    end
  endgenerate

  assign out_valid = vld_q[RD_LAT-1];
  assign out_addr  = addr_q[RD_LAT-1];

endmodule

// File: rtl/xcorr_peak_finder.sv
// Scans the cross-correlation result RAM once per start edge and reports the
// peak sample, its address and its signed lag relative to the zero-lag address.
module xcorr_peak_finder
  import mic_pkg::*;
#(
  parameter int ADDR_W = XC_ADDR_W,
  parameter int DATA_W = XC_DATA_W,
  parameter int DEPTH  = 256,
  parameter int RD_LAT = 1,
  parameter int SIGNED = 1,
  parameter int CENTER = XC_CENTER
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] r_addr,
  input  logic [DATA_W-1:0] r_data,
  output logic              busy,
  output logic              valid,
  output logic [DATA_W-1:0] max_val,
  output logic [ADDR_W-1:0] max_idx,
  output logic [ADDR_W:0]   lag
);

  localparam int              CNT_W      = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  DRAIN_LAST = CNT_W'(RD_LAT - 1);
  localparam logic [ADDR_W:0]   CENTER_EXT = (ADDR_W + 1)'(CENTER);

  peak_state_t       state_q, state_d;
  logic              prev_start_q;
  logic [ADDR_W-1:0] r_addr_q, r_addr_d;
  logic [CNT_W-1:0]  drain_cnt_q, drain_cnt_d;
  logic [DATA_W-1:0] best_val_q, best_val_d;
  logic [ADDR_W-1:0] best_idx_q, best_idx_d;
  logic [DATA_W-1:0] max_val_q, max_val_d;
  logic [ADDR_W-1:0] max_idx_q, max_idx_d;
  logic              valid_q, valid_d;

  logic              start_edge;
  logic              rd_valid;
  logic [ADDR_W-1:0] rd_addr;
  logic              sample_gt;

  assign start_edge = start & ~prev_start_q;

  rd_align_pipe #(
    .ADDR_W (ADDR_W),
    .RD_LAT (RD_LAT)
  ) u_rd_align (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (state_q == READ),
    .in_addr   (r_addr_q),
    .out_valid (rd_valid),
    .out_addr  (rd_addr)
  );

  // Address 0 seeds the running best; strict compare keeps the lowest address on ties.
  always_comb begin
    best_val_d = best_val_q;
    best_idx_d = best_idx_q;
    if (SIGNED != 0) begin
      sample_gt = $signed(r_data) > $signed(best_val_q);
    end else begin
      sample_gt = r_data > best_val_q;
    end
    if (rd_valid && ((rd_addr == '0) || sample_gt)) begin
      best_val_d = r_data;
      best_idx_d = rd_addr;
    end
  end

  always_comb begin
    state_d     = state_q;
    r_addr_d    = '0;
    drain_cnt_d = '0;
    max_val_d   = max_val_q;
    max_idx_d   = max_idx_q;
    valid_d     = valid_q;
    case (state_q)
      IDLE: begin
        if (start_edge) begin
          state_d = READ;
          valid_d = 1'b0;
        end
      end
      READ: begin
        if (r_addr_q == LAST_ADDR) begin
          state_d = DRAIN;
        end else begin
          r_addr_d = r_addr_q + 1'b1;
        end
      end
      DRAIN: begin
        // The final sample is folded in via best_*_d in the same cycle it arrives.
        if (drain_cnt_q == DRAIN_LAST) begin
          state_d   = DONE;
          max_val_d = best_val_d;
          max_idx_d = best_idx_d;
          valid_d   = 1'b1;
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      prev_start_q <= 1'b0;
      r_addr_q     <= '0;
      drain_cnt_q  <= '0;
      best_val_q   <= '0;
      best_idx_q   <= '0;
      max_val_q    <= '0;
      max_idx_q    <= '0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_start_q <= start;
      r_addr_q     <= r_addr_d;
      drain_cnt_q  <= drain_cnt_d;
      best_val_q   <= best_val_d;
      best_idx_q   <= best_idx_d;
      max_val_q    <= max_val_d;
      max_idx_q    <= max_idx_d;
      valid_q      <= valid_d;
    end
  end

  assign r_addr  = r_addr_q;
  assign busy    = (state_q == READ) || (state_q == DRAIN);
  assign valid   = valid_q;
  assign max_val = max_val_q;
  assign max_idx = max_idx_q;
  assign lag     = {1'b0, max_idx_q} - CENTER_EXT;

endmodule

// File: tb/tb_xcorr_peak_finder.sv
// Self-checking bench: three peak finders (signed/RD_LAT=1, unsigned/RD_LAT=1,
// signed/RD_LAT=2) scan a shared result RAM loaded with directed patterns.
module tb_xcorr_peak_finder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  int         cyc = 0;

  logic [7:0] ram [256];

  logic [7:0] r_addr_s, r_addr_u, r_addr_s2;
  logic [7:0] rd_s, rd_u, rd_s2_a, rd_s2;
  logic       busy_s, busy_u, busy_s2;
  logic       valid_s, valid_u, valid_s2;
  logic [7:0] max_val_s, max_val_u, max_val_s2;
  logic [7:0] max_idx_s, max_idx_u, max_idx_s2;
  logic [8:0] lag_s, lag_u, lag_s2;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    rd_s    <= ram[r_addr_s];
    rd_u    <= ram[r_addr_u];
    rd_s2_a <= ram[r_addr_s2];
    rd_s2   <= rd_s2_a;
  end

  xcorr_peak_finder #(.RD_LAT(1), .SIGNED(1)) u_dut_s (
    .clk(clk), .reset(reset), .start(start), .r_addr(r_addr_s), .r_data(rd_s),
    .busy(busy_s), .valid(valid_s), .max_val(max_val_s), .max_idx(max_idx_s), .lag(lag_s)
  );

  xcorr_peak_finder #(.RD_LAT(1), .SIGNED(0)) u_dut_u (
    .clk(clk), .reset(reset), .start(start), .r_addr(r_addr_u), .r_data(rd_u),
    .busy(busy_u), .valid(valid_u), .max_val(max_val_u), .max_idx(max_idx_u), .lag(lag_u)
  );

  xcorr_peak_finder #(.RD_LAT(2), .SIGNED(1)) u_dut_s2 (
    .clk(clk), .reset(reset), .start(start), .r_addr(r_addr_s2), .r_data(rd_s2),
    .busy(busy_s2), .valid(valid_s2), .max_val(max_val_s2), .max_idx(max_idx_s2), .lag(lag_s2)
  );

  typedef struct {
    int pat;
    int retrig;
    int s_val; int s_idx; int s_lag;
    int u_val; int u_idx; int u_lag;
  } vec_t;

  vec_t vecs [7];
  int   prev_s_val = 0;
  int   prev_u_val = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic fill(input int pat);
    for (int i = 0; i < 256; i++) begin
      case (pat)
        0: ram[i] = 8'(i ^ 128);
        1: ram[i] = (i == 200) ? 8'h40 : 8'h00;
        2: ram[i] = (i == 10 || i == 50) ? 8'h30 : 8'h10;
        3: ram[i] = 8'h80;
        4: ram[i] = (i == 5) ? 8'h80 : 8'h01;
        5: ram[i] = (i == 255) ? 8'h7E : 8'h20;
        default: ram[i] = (i == 0) ? 8'hFE : 8'hFF;
      endcase
    end
  endtask

  // Caller is 1 time unit after a rising edge; that cycle becomes k.
  task automatic run_scan(input int retrig, output int t_s, output int t_u, output int t_s2);
    int k;
    k = cyc;
    start = 1'b1;
    t_s = -1; t_u = -1; t_s2 = -1;
    for (int n = 0; n < 300; n++) begin
      @(posedge clk); #1;
      if (n == 0) begin
        start = 1'b0;
        check("busy_at_k1", int'(busy_s), 1);
        check("valid_at_k1", int'(valid_s), 0);
        check("raddr_at_k1", int'(r_addr_s), 0);
      end else begin
        if (valid_s  && t_s  < 0) t_s  = cyc - k;
        if (valid_u  && t_u  < 0) t_u  = cyc - k;
        if (valid_s2 && t_s2 < 0) t_s2 = cyc - k;
      end
      if (n == 10) begin
        check("held_val_s", int'(max_val_s), prev_s_val);
        check("held_val_u", int'(max_val_u), prev_u_val);
      end
      if (n == 255) check("raddr_last", int'(r_addr_s), 255);
      if (retrig != 0 && n == 50) start = 1'b1;
      if (retrig != 0 && n == 52) start = 1'b0;
    end
  endtask

  initial begin
    int t_s, t_u, t_s2, k, tr, busy_starts;
    logic prev_busy;

    vecs[0] = '{0, 0, 8'h7F, 255,  127, 8'hFF, 127,   -1};
    vecs[1] = '{1, 0, 8'h40, 200,   72, 8'h40, 200,   72};
    vecs[2] = '{2, 0, 8'h30,  10, -118, 8'h30,  10, -118};
    vecs[3] = '{3, 0, 8'h80,   0, -128, 8'h80,   0, -128};
    vecs[4] = '{4, 0, 8'h01,   0, -128, 8'h80,   5, -123};
    vecs[5] = '{5, 1, 8'h7E, 255,  127, 8'h7E, 255,  127};
    vecs[6] = '{6, 0, 8'hFF,   1, -127, 8'hFF,   1, -127};

    fill(0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_raddr", int'(r_addr_s), 0);
    check("rst_busy", int'(busy_s), 0);
    check("rst_valid", int'(valid_s), 0);
    check("rst_max_val", int'(max_val_s), 0);
    check("rst_max_idx", int'(max_idx_s), 0);
    check("rst_lag", int'($signed(lag_s)), -128);
    $display("reset: r_addr=%0d busy=%0d valid=%0d lag=%0d",
             r_addr_s, busy_s, valid_s, $signed(lag_s));
    @(posedge clk); #1;

    for (int v = 0; v < 7; v++) begin
      fill(vecs[v].pat);
      run_scan(vecs[v].retrig, t_s, t_u, t_s2);
      check("valid_time_s", t_s, 258);
      check("valid_time_u", t_u, 258);
      check("valid_time_s2", t_s2, 259);
      check("max_val_s", int'(max_val_s), vecs[v].s_val);
      check("max_idx_s", int'(max_idx_s), vecs[v].s_idx);
      check("lag_s", int'($signed(lag_s)), vecs[v].s_lag);
      check("max_val_u", int'(max_val_u), vecs[v].u_val);
      check("max_idx_u", int'(max_idx_u), vecs[v].u_idx);
      check("lag_u", int'($signed(lag_u)), vecs[v].u_lag);
      check("max_val_s2", int'(max_val_s2), vecs[v].s_val);
      check("max_idx_s2", int'(max_idx_s2), vecs[v].s_idx);
      check("lag_s2", int'($signed(lag_s2)), vecs[v].s_lag);
      check("busy_after", int'(busy_s2), 0);
      prev_s_val = vecs[v].s_val;
      prev_u_val = vecs[v].u_val;
      $display("scan pat=%0d: s val=%02h idx=%0d lag=%0d t=%0d | u val=%02h idx=%0d lag=%0d t=%0d | s2 idx=%0d t=%0d",
               vecs[v].pat, max_val_s, max_idx_s, $signed(lag_s), t_s,
               max_val_u, max_idx_u, $signed(lag_u), t_u, max_idx_s2, t_s2);
    end

    // Abort a scan with reset at k+100 while start is held, then release.
    k = cyc;
    start = 1'b1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (n == 1) start = 1'b0;
    end
    check("abort_cycle", cyc - k, 100);
    reset = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", int'(busy_s), 0);
    check("abort_valid", int'(valid_s), 0);
    check("abort_raddr", int'(r_addr_s), 0);
    check("abort_max_val", int'(max_val_s), 0);
    check("abort_max_idx", int'(max_idx_s), 0);
    $display("reset at k+100: busy=%0d valid=%0d r_addr=%0d", busy_s, valid_s, r_addr_s);

    reset = 1'b0;
    k = cyc;
    tr = -1;
    busy_starts = 0;
    prev_busy = busy_s;
    for (int n = 0; n < 400; n++) begin
      @(posedge clk); #1;
      if (busy_s && !prev_busy) busy_starts++;
      prev_busy = busy_s;
      if (valid_s && tr < 0) tr = cyc - k;
    end
    check("held_start_valid_time", tr, 258);
    check("held_start_scans", busy_starts, 1);
    check("held_start_idx", int'(max_idx_s), 1);
    check("held_start_valid", int'(valid_s), 1);
    $display("start held through reset: scans=%0d valid_time=%0d idx=%0d",
             busy_starts, tr, max_idx_s);
    start = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", passed, total);
    $fatal(1);
  end

endmodule
